// File: rtl/pc_ras.sv
// Program counter with an integrated circular return-address stack.
// The PC and every stack-visible value (top, count, flags) are registered.
// The stack can therefore be observed without any combinational path from the inputs.
module pc_ras #(
  parameter int          WIDTH     = 16,
  parameter int unsigned RESET_VEC = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4,
  localparam int         CW        = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_pc,
  input  logic [1:0]       pcmux,
  input  logic [WIDTH-1:0] from_bus,
  input  logic [WIDTH-1:0] addr,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ras_top,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int             PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [WIDTH-1:0] RST_PC   = RESET_VEC[WIDTH-1:0];
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [PW-1:0]    LAST_IDX = PW'(RAS_DEPTH - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] top_q, top_d;     // registered copy of the entry at ptr_q
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    ptr_next, ptr_prev;
  logic             set_ovf, set_unf;

  // Next-state logic: stack operation, flag update and PC select.
  always_comb begin
    pc_inc   = pc_q + WIDTH'(1);
    ptr_next = (ptr_q == LAST_IDX) ? '0 : ptr_q + PW'(1);
    ptr_prev = (ptr_q == '0) ? LAST_IDX : ptr_q - PW'(1);

    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = pc_inc;
    set_ovf = 1'b0;
    set_unf = 1'b0;

    if (push && pop && (cnt_q != '0)) begin
      // Call immediately replacing a return: overwrite the top in place.
      wr_en = 1'b1;
      top_d = pc_inc;
    end else if (push) begin
      // A push onto a full stack silently drops the oldest entry.
      ptr_d  = ptr_next;
      wr_en  = 1'b1;
      wr_idx = ptr_next;
      top_d  = pc_inc;
      if (cnt_q == FULL_CNT) begin
        set_ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop) begin
      if (cnt_q != '0) begin
        ptr_d = ptr_prev;
        cnt_d = cnt_q - CW'(1);
        // Stale entries stay hidden: an emptied stack shows the reset vector.
        top_d = (cnt_q == CW'(1)) ? RST_PC : mem[ptr_prev];
      end else begin
        set_unf = 1'b1;
      end
    end

    // Sticky flags; a new event outranks a simultaneous clear.
    ovf_d = (ovf_q & ~clr_flags) | set_ovf;
    unf_d = (unf_q & ~clr_flags) | set_unf;

    pc_d = pc_q;
    if (ld_pc) begin
      case (pcmux)
        2'b00:   pc_d = pc_inc;
        2'b01:   pc_d = from_bus;
        2'b10:   pc_d = addr;
        default: pc_d = top_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RST_PC;
      top_q <= RST_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage; never cleared, only reachable while the count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign pc        = pc_q;
  assign ras_top   = top_q;
  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL_CNT);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Randomized and directed bench for pc_ras.
// Two instances run side by side: 16-bit with depth 4, and 12-bit with depth 3.
// The reference model is a list-based stack in which an overflow shifts out the oldest entry.
module tb_pc_ras;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_pc = 1'b0;
  logic [1:0]  pcmux = 2'b00;
  logic [15:0] from_bus = '0;
  logic [15:0] addr = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_flags = 1'b0;

  logic [15:0] pc_a, top_a;
  logic [2:0]  cnt_a;
  logic        emp_a, full_a, ovf_a, unf_a;
  logic [11:0] pc_b, top_b;
  logic [1:0]  cnt_b;
  logic        emp_b, full_b, ovf_b, unf_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_ras #(.WIDTH(16), .RESET_VEC(32'h3000), .RAS_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .ld_pc(ld_pc), .pcmux(pcmux),
    .from_bus(from_bus), .addr(addr), .push(push), .pop(pop),
    .clr_flags(clr_flags), .pc(pc_a), .ras_top(top_a), .ras_count(cnt_a),
    .ras_empty(emp_a), .ras_full(full_a), .ras_ovf(ovf_a), .ras_unf(unf_a)
  );

  pc_ras #(.WIDTH(12), .RESET_VEC(32'h3000), .RAS_DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .ld_pc(ld_pc), .pcmux(pcmux),
    .from_bus(from_bus[11:0]), .addr(addr[11:0]), .push(push), .pop(pop),
    .clr_flags(clr_flags), .pc(pc_b), .ras_top(top_b), .ras_count(cnt_b),
    .ras_empty(emp_b), .ras_full(full_b), .ras_ovf(ovf_b), .ras_unf(unf_b)
  );

  // Reference model state, index 0 = instance a, 1 = instance b.
  int          m_w [2] = '{16, 12};
  int          m_d [2] = '{4, 3};
  int unsigned m_pc [2];
  int unsigned m_stk [2][16];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];

  function automatic int unsigned mask(int i);
    return (32'd1 << m_w[i]) - 32'd1;
  endfunction

  function automatic int unsigned model_top(int i);
    return (m_cnt[i] > 0) ? m_stk[i][m_cnt[i]-1] : (32'h3000 & mask(i));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]  = 32'h3000 & mask(i);
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
  endtask

  // Apply one clock edge to the model using the current input values.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int unsigned msk = mask(i);
      int unsigned pc1 = (m_pc[i] + 1) & msk;
      int unsigned top = model_top(i);
      int unsigned npc = m_pc[i];
      bit so = 1'b0;
      bit su = 1'b0;
      if (ld_pc) begin
        case (pcmux)
          2'd0:    npc = pc1;
          2'd1:    npc = from_bus & msk;
          2'd2:    npc = addr & msk;
          default: npc = top;
        endcase
      end
      if (push && pop && m_cnt[i] > 0) begin
        m_stk[i][m_cnt[i]-1] = pc1;
      end else if (push) begin
        if (m_cnt[i] == m_d[i]) begin
          for (int k = 0; k < m_d[i] - 1; k++) m_stk[i][k] = m_stk[i][k+1];
          m_stk[i][m_d[i]-1] = pc1;
          so = 1'b1;
        end else begin
          m_stk[i][m_cnt[i]] = pc1;
          m_cnt[i]++;
        end
      end else if (pop) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        else su = 1'b1;
      end
      m_ovf[i] = (m_ovf[i] && !clr_flags) || so;
      m_unf[i] = (m_unf[i] && !clr_flags) || su;
      m_pc[i]  = npc;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a_pc"},    32'(pc_a),   m_pc[0]);
    chk({tag, "_a_top"},   32'(top_a),  model_top(0));
    chk({tag, "_a_cnt"},   32'(cnt_a),  32'(m_cnt[0]));
    chk({tag, "_a_empty"}, 32'(emp_a),  32'(m_cnt[0] == 0));
    chk({tag, "_a_full"},  32'(full_a), 32'(m_cnt[0] == m_d[0]));
    chk({tag, "_a_ovf"},   32'(ovf_a),  32'(m_ovf[0]));
    chk({tag, "_a_unf"},   32'(unf_a),  32'(m_unf[0]));
    chk({tag, "_b_pc"},    32'(pc_b),   m_pc[1]);
    chk({tag, "_b_top"},   32'(top_b),  model_top(1));
    chk({tag, "_b_cnt"},   32'(cnt_b),  32'(m_cnt[1]));
    chk({tag, "_b_empty"}, 32'(emp_b),  32'(m_cnt[1] == 0));
    chk({tag, "_b_full"},  32'(full_b), 32'(m_cnt[1] == m_d[1]));
    chk({tag, "_b_ovf"},   32'(ovf_b),  32'(m_ovf[1]));
    chk({tag, "_b_unf"},   32'(unf_b),  32'(m_unf[1]));
  endtask

  // One clocked transaction: drive, clock, step the model, compare.
  task automatic cycle(input string tag, input logic ld, input logic [1:0] mux,
                       input logic [15:0] fb, input logic [15:0] ad,
                       input logic ps, input logic pp, input logic cl);
    ld_pc = ld; pcmux = mux; from_bus = fb; addr = ad;
    push = ps; pop = pp; clr_flags = cl;
    @(posedge clk);
    model_step();
    #1;
    $display("%s ld=%0b mux=%0d push=%0b pop=%0b clr=%0b | a: pc=%h top=%h cnt=%0d | b: pc=%h top=%h cnt=%0d",
             tag, ld, mux, ps, pp, cl, pc_a, top_a, cnt_a, pc_b, top_b, cnt_b);
    check_all(tag);
  endtask

  // Asynchronous reset between edges; outputs must react without a clock.
  task automatic do_reset(input string tag);
    ld_pc = 1'b0; push = 1'b0; pop = 1'b0; clr_flags = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    $display("%s reset asserted | a: pc=%h cnt=%0d | b: pc=%h cnt=%0d", tag, pc_a, cnt_a, pc_b, cnt_b);
    check_all(tag);
    chk({tag, "_a_pc_vec"}, 32'(pc_a), 32'h3000);
    chk({tag, "_a_top_vec"}, 32'(top_a), 32'h3000);
    chk({tag, "_a_empty1"}, 32'(emp_a), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset("init");

    // Sequential increment out of reset.
    cycle("inc0", 1, 2'd0, 16'h0, 16'h0, 0, 0, 0); chk("inc0_pc", 32'(pc_a), 32'h3001);
    cycle("inc1", 1, 2'd0, 16'h0, 16'h0, 0, 0, 0); chk("inc1_pc", 32'(pc_a), 32'h3002);
    cycle("inc2", 1, 2'd0, 16'h0, 16'h0, 0, 0, 0); chk("inc2_pc", 32'(pc_a), 32'h3003);

    // Call and return.
    cycle("ldbus", 1, 2'd1, 16'h3005, 16'h0, 0, 0, 0);
    cycle("call", 1, 2'd2, 16'h0, 16'h4000, 1, 0, 0);
    chk("call_pc", 32'(pc_a), 32'h4000);
    chk("call_top", 32'(top_a), 32'h3006);
    chk("call_cnt", 32'(cnt_a), 32'd1);
    cycle("ret", 1, 2'd3, 16'h0, 16'h0, 0, 1, 0);
    chk("ret_pc", 32'(pc_a), 32'h3006);
    chk("ret_empty", 32'(emp_a), 32'd1);

    // Overflow: five pushes into a four-deep stack, then four returns.
    cycle("ld10", 1, 2'd1, 16'h0010, 16'h0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle("ovpush", 1, 2'd0, 16'h0, 16'h0, 1, 0, 0);
    chk("ov_full", 32'(full_a), 32'd1);
    chk("ov_flag", 32'(ovf_a), 32'd1);
    chk("ov_cnt", 32'(cnt_a), 32'd4);
    for (int k = 0; k < 4; k++) begin
      cycle("ovpop", 1, 2'd3, 16'h0, 16'h0, 0, 1, 0);
      chk("ovpop_pc", 32'(pc_a), 32'h0015 - 32'(k));
    end

    // Underflow returns the reset vector; clear drops the flags.
    cycle("unf", 1, 2'd3, 16'h0, 16'h0, 0, 1, 0);
    chk("unf_pc", 32'(pc_a), 32'h3000);
    chk("unf_flag", 32'(unf_a), 32'd1);
    cycle("clr", 0, 2'd0, 16'h0, 16'h0, 0, 0, 1);
    chk("clr_unf", 32'(unf_a), 32'd0);

    // PC wrap and simultaneous push/pop.
    cycle("ldffff", 1, 2'd1, 16'hFFFF, 16'h0, 0, 0, 0);
    chk("wrap_ff", 32'(pc_a), 32'hFFFF);
    cycle("wrap", 1, 2'd0, 16'h0, 16'h0, 0, 0, 0);
    chk("wrap_0", 32'(pc_a), 32'h0000);
    cycle("pushA", 0, 2'd0, 16'h0, 16'h0, 1, 0, 0);
    cycle("pushB", 0, 2'd0, 16'h0, 16'h0, 1, 0, 0);
    cycle("pp", 0, 2'd0, 16'h0, 16'h0, 1, 1, 0);
    chk("pp_cnt", 32'(cnt_a), 32'd2);
    chk("pp_top", 32'(top_a), 32'h0001);

    // Reset while the stack holds entries.
    cycle("pre_rst", 1, 2'd2, 16'h0, 16'h1234, 1, 0, 0);
    do_reset("midrst");
    cycle("post_rst", 1, 2'd3, 16'h0, 16'h0, 0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        logic [15:0] fb;
        logic [15:0] ad;
        logic        ps;
        logic        pp;
        fb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        ad = 16'($urandom);
        ps = ($urandom_range(0, 2) == 0);
        pp = ($urandom_range(0, 2) == 0);
        cycle("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), fb, ad,
              ps, pp, ($urandom_range(0, 9) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 Parameter WIDTH, default 16, PC and data-path width in bits (legal values 8..32).
REQ-002 Parameter RESET_VEC, default 16'h3000 (zero-extended or truncated to WIDTH), PC value after reset.
REQ-003 Parameter RAS_DEPTH, default 4, number of return-address-stack entries (legal values 2..16, any integer).
REQ-004 Local parameter CW = $clog2(RAS_DEPTH+1), width of the stack occupancy count.
REQ-005 clk  input  1  clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ld_pc  input  1  PC load enable.
REQ-008 pcmux  input  2  next-PC select: 00 PC+1, 01 from_bus, 10 addr, 11 stack top (return).
REQ-009 from_bus  input  WIDTH  value from the global bus.
REQ-010 addr  input  WIDTH  target from the address adder.
REQ-011 push  input  1  push PC+1 onto the return stack (subroutine call).
REQ-012 pop  input  1  pop the return stack (subroutine return).
REQ-013 clr_flags  input  1  synchronous clear of the sticky error flags.
REQ-014 pc  output  WIDTH  current PC register value.
REQ-015 ras_top  output  WIDTH  current stack top; RESET_VEC when the stack is empty.
REQ-016 ras_count  output  CW  number of valid stack entries, 0..RAS_DEPTH.
REQ-017 ras_empty / ras_full  output  1 each  ras_count==0 / ras_count==RAS_DEPTH.
REQ-018 ras_ovf / ras_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-019 pc+1 and all PC arithmetic SHALL be computed modulo 2^WIDTH, so all-ones+1 wraps to 0.
REQ-020 On a rising clk edge with ld_pc=1, pc SHALL load the value selected by pcmux; with ld_pc=0, pc SHALL hold.
REQ-021 pcmux=11 SHALL select the pre-edge ras_top value, including the RESET_VEC value returned when the stack is empty.
REQ-022 The stack SHALL be a circular buffer with a top pointer and count; ras_top, ras_count and the flags SHALL be registered outputs, with no combinational path from the inputs.
REQ-023 push alone, count<RAS_DEPTH: write pre-edge pc+1 at the new top; count+1.
REQ-024 push alone, count==RAS_DEPTH: overwrite the oldest entry (pointer advances, wraps); count stays RAS_DEPTH; set ras_ovf.
REQ-025 pop alone, count>0: top moves to the previous entry; count-1.
REQ-026 pop alone, count==0: stack unchanged; set ras_unf.
REQ-027 push and pop in the same cycle: replace the top entry with pc+1 and leave count unchanged; if count==0, treat the operation as a push with no underflow.
REQ-028 push and pop SHALL act independently of ld_pc and pcmux; a normal return is pop=1, ld_pc=1, pcmux=11 in one cycle.
REQ-029 ras_ovf and ras_unf SHALL stay set until clr_flags or reset; if clr_flags and a set condition occur in the same cycle, set wins.
REQ-030 The block SHALL produce no X on any output after reset for any input sequence.

Reset
REQ-031 While reset=1, pc SHALL be RESET_VEC, ras_count SHALL be 0, ras_empty SHALL be 1, ras_full, ras_ovf and ras_unf SHALL be 0, and ras_top SHALL be RESET_VEC, all applied immediately and independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard all stack contents; entry storage need not be cleared but SHALL never be visible while ras_count==0.
REQ-033 The first edge after reset deasserts SHALL behave as a normal cycle.

Verification
REQ-034 Reset, then 3 cycles of ld_pc=1, pcmux=00 -> pc = 3000, 3001, 3002, 3003.
REQ-035 pc=3005, push=1, ld_pc=1, pcmux=10, addr=4000 -> pc=4000, ras_top=3006, ras_count=1; then pop=1, ld_pc=1, pcmux=11 -> pc=3006, ras_count=0, ras_empty=1.
REQ-036 Five pushes with RAS_DEPTH=4 from pc=0010..0014 -> ras_full=1, ras_ovf=1, ras_count=4; four pops then return 0015, 0014, 0013, 0012.
REQ-037 pop on empty stack with pcmux=11 -> pc=3000 (RESET_VEC), ras_unf=1; clr_flags=1 -> ras_unf=0 the next cycle.
REQ-038 ld_pc=1, pcmux=01, from_bus=FFFF, then pcmux=00 -> pc=FFFF, then 0000; simultaneous push and pop with count=2 -> count stays 2, top=0001.
REQ-039 Re-run REQ-034 to REQ-038 with WIDTH=12, RAS_DEPTH=3, and assert reset mid-sequence -> outputs match the REQ-031 values in the same cycle.
